// File: rtl/ann_layer_sequencer.sv
// Walks sample/layer/row/col for the shared MAC->bias->activation datapath and scores each sample.
// Outputs registered from next state (mac_clr one cycle after start); stalls in ACT_WAIT on act_done, aborts to IDLE when enable drops.
module ann_layer_sequencer #(
    parameter int ROWS0      = 30,
    parameter int COLS0      = 64,
    parameter int ROWS1      = 10,
    parameter int COLS1      = 30,
    parameter int MAX_ROWS   = 30,
    parameter int MAX_COLS   = 64,
    parameter int MAX_INPUTS = 300
) (
    input  logic                              clk,
    input  logic                              rst_overall_n,
    input  logic                              enable_inference,
    input  logic                              upload_done,
    input  logic                              act_done,
    input  logic [ROWS1-1:0]                  expected_output,
    input  logic [ROWS1-1:0]                  obtained_output,
    output logic                              layer_idx,
    output logic [$clog2(MAX_ROWS)-1:0]       row_addr,
    output logic [$clog2(MAX_COLS)-1:0]       col_addr,
    output logic [$clog2(MAX_INPUTS+1)-1:0]   sample_idx,
    output logic                              mac_clr,
    output logic                              mac_en,
    output logic                              bias_en,
    output logic                              act_start,
    output logic                              sample_done,
    output logic [$clog2(MAX_INPUTS+1)-1:0]   correct_cnt,
    output logic                              final_done,
    output logic                              busy
);
    localparam int RW = $clog2(MAX_ROWS);
    localparam int CW = $clog2(MAX_COLS);
    localparam int SW = $clog2(MAX_INPUTS + 1);

    localparam logic [RW-1:0] R0_LAST = RW'(ROWS0 - 1);
    localparam logic [RW-1:0] R1_LAST = RW'(ROWS1 - 1);
    localparam logic [CW-1:0] C0_LAST = CW'(COLS0 - 1);
    localparam logic [CW-1:0] C1_LAST = CW'(COLS1 - 1);
    localparam logic [SW-1:0] S_LAST  = SW'(MAX_INPUTS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_MAC, S_BIAS, S_ACT_START, S_ACT_WAIT, S_SCORE, S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic            layer_q, layer_d;
    logic [RW-1:0]   row_q, row_d;
    logic [CW-1:0]   col_q, col_d;
    logic [SW-1:0]   sample_q, sample_d;
    logic [SW-1:0]   correct_q, correct_d;
    logic            mac_clr_q, mac_clr_d;
    logic            mac_en_q, mac_en_d;
    logic            bias_en_q, bias_en_d;
    logic            act_start_q, act_start_d;
    logic            sample_done_q, sample_done_d;
    logic            final_done_q, final_done_d;
    logic            busy_q, busy_d;

    logic [CW-1:0]   col_last;
    logic [RW-1:0]   row_last;
    logic            in_busy_state;

    assign col_last      = layer_q ? C1_LAST : C0_LAST;
    assign row_last      = layer_q ? R1_LAST : R0_LAST;
    assign in_busy_state = (state_q != S_IDLE) && (state_q != S_DONE);

    always_comb begin
        state_d   = state_q;
        layer_d   = layer_q;
        row_d     = row_q;
        col_d     = col_q;
        sample_d  = sample_q;
        correct_d = correct_q;

        // Abort freezes every counter; they are only cleared by the next start.
        if (in_busy_state && !enable_inference) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (enable_inference && upload_done) begin
                        layer_d   = 1'b0;
                        row_d     = '0;
                        sample_d  = '0;
                        correct_d = '0;
                        state_d   = S_CLEAR;
                    end
                end
                S_CLEAR:     state_d = S_MAC;
                S_MAC: begin
                    if (col_q == col_last) begin
                        state_d = S_BIAS;
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
                S_BIAS:      state_d = S_ACT_START;
                S_ACT_START: state_d = S_ACT_WAIT;
                S_ACT_WAIT: begin
                    if (act_done) begin
                        if (row_q < row_last) begin
                            row_d   = row_q + RW'(1);
                            state_d = S_CLEAR;
                        end else if (!layer_q) begin
                            layer_d = 1'b1;
                            row_d   = '0;
                            state_d = S_CLEAR;
                        end else begin
                            state_d = S_SCORE;
                        end
                    end
                end
                S_SCORE: begin
                    if (obtained_output == expected_output) begin
                        correct_d = correct_q + SW'(1);
                    end
                    if (sample_q == S_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        sample_d = sample_q + SW'(1);
                        layer_d  = 1'b0;
                        row_d    = '0;
                        state_d  = S_CLEAR;
                    end
                end
                S_DONE: begin
                    if (!enable_inference) begin
                        state_d = S_IDLE;
                    end
                end
                default:     state_d = S_IDLE;
            endcase
        end

        // Column index reads 0 already during the CLEAR cycle.
        if (state_d == S_CLEAR) begin
            col_d = '0;
        end

        mac_clr_d     = (state_d == S_CLEAR);
        mac_en_d      = (state_d == S_MAC);
        bias_en_d     = (state_d == S_BIAS);
        act_start_d   = (state_d == S_ACT_START);
        sample_done_d = (state_d == S_SCORE);
        final_done_d  = (state_d == S_DONE);
        busy_d        = (state_d != S_IDLE) && (state_d != S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_overall_n) begin
            state_q       <= S_IDLE;
            layer_q       <= 1'b0;
            row_q         <= '0;
            col_q         <= '0;
            sample_q      <= '0;
            correct_q     <= '0;
            mac_clr_q     <= 1'b0;
            mac_en_q      <= 1'b0;
            bias_en_q     <= 1'b0;
            act_start_q   <= 1'b0;
            sample_done_q <= 1'b0;
            final_done_q  <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            layer_q       <= layer_d;
            row_q         <= row_d;
            col_q         <= col_d;
            sample_q      <= sample_d;
            correct_q     <= correct_d;
            mac_clr_q     <= mac_clr_d;
            mac_en_q      <= mac_en_d;
            bias_en_q     <= bias_en_d;
            act_start_q   <= act_start_d;
            sample_done_q <= sample_done_d;
            final_done_q  <= final_done_d;
            busy_q        <= busy_d;
        end
    end

    assign layer_idx   = layer_q;
    assign row_addr    = row_q;
    assign col_addr    = col_q;
    assign sample_idx  = sample_q;
    assign correct_cnt = correct_q;
    assign mac_clr     = mac_clr_q;
    assign mac_en      = mac_en_q;
    assign bias_en     = bias_en_q;
    assign act_start   = act_start_q;
    assign sample_done = sample_done_q;
    assign final_done  = final_done_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_ann_layer_sequencer.sv
// Bench for ann_layer_sequencer: gating/reset vector table, then per-cycle comparison against a timeline built from nested sample/layer/row loops.
module tb_ann_layer_sequencer;
    localparam int R0 = 3;
    localparam int C0 = 4;
    localparam int R1 = 2;
    localparam int C1 = 3;
    localparam int MI = 2;
    localparam int MR = 30;
    localparam int MC = 64;
    localparam int RW = $clog2(MR);
    localparam int CW = $clog2(MC);
    localparam int SW = $clog2(MI + 1);
    localparam int MACS_PER_RUN = MI * (R0 * C0 + R1 * C1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_overall_n, enable_inference, upload_done, act_done;
    logic [R1-1:0] expected_output, obtained_output;
    logic          layer_idx;
    logic [RW-1:0] row_addr;
    logic [CW-1:0] col_addr;
    logic [SW-1:0] sample_idx, correct_cnt;
    logic          mac_clr, mac_en, bias_en, act_start, sample_done, final_done, busy;

    int checks = 0;
    int failures = 0;

    ann_layer_sequencer #(
        .ROWS0(R0), .COLS0(C0), .ROWS1(R1), .COLS1(C1),
        .MAX_ROWS(MR), .MAX_COLS(MC), .MAX_INPUTS(MI)
    ) dut (
        .clk(clk), .rst_overall_n(rst_overall_n),
        .enable_inference(enable_inference), .upload_done(upload_done),
        .act_done(act_done), .expected_output(expected_output),
        .obtained_output(obtained_output), .layer_idx(layer_idx),
        .row_addr(row_addr), .col_addr(col_addr), .sample_idx(sample_idx),
        .mac_clr(mac_clr), .mac_en(mac_en), .bias_en(bias_en),
        .act_start(act_start), .sample_done(sample_done),
        .correct_cnt(correct_cnt), .final_done(final_done), .busy(busy)
    );

    // ---------------- vector table ----------------
    typedef struct {
        bit rst_n, en, upl;
        bit busy, clr, mac, fdone, zero;
    } tv_t;
    tv_t tv[19];

    // ---------------- timeline model ----------------
    typedef enum int {K_CLEAR, K_MAC, K_BIAS, K_ACTS, K_WAIT, K_SCORE, K_DONE, K_IDLE} kind_t;
    typedef struct {
        int layer, row, col, sample, correct;
        bit clr, mac, bias, acts, sdone, fdone, busy;
        bit act_req, is_wait, new_samp, en;
    } rec_t;
    rec_t trace[$];
    bit   match_a[MI];
    int   mac_cnt, fd_first;
    int   sd_cyc[$];

    function automatic int n_wait(int mode, int s, int l, int r);
        if (mode == 1) return (s == 0 && l == 0 && r == 1) ? 6 : 1;
        if (mode == 2) return int'($urandom_range(1, 4));
        return 1;
    endfunction

    task automatic add(kind_t k, int l, int r, int c, int s, int corr, bit req, bit ns, bit en);
        rec_t e;
        e.layer = l; e.row = r; e.col = c; e.sample = s; e.correct = corr;
        e.clr   = (k == K_CLEAR);
        e.mac   = (k == K_MAC);
        e.bias  = (k == K_BIAS);
        e.acts  = (k == K_ACTS);
        e.sdone = (k == K_SCORE);
        e.fdone = (k == K_DONE);
        e.busy  = (k != K_DONE) && (k != K_IDLE);
        e.act_req = req; e.is_wait = (k == K_WAIT); e.new_samp = ns; e.en = en;
        trace.push_back(e);
    endtask

    task automatic build(int mode);
        int corr = 0;
        trace.delete();
        for (int s = 0; s < MI; s++) begin
            for (int l = 0; l < 2; l++) begin
                int rows = (l == 1) ? R1 : R0;
                int cols = (l == 1) ? C1 : C0;
                for (int r = 0; r < rows; r++) begin
                    int n = n_wait(mode, s, l, r);
                    add(K_CLEAR, l, r, 0, s, corr, 1'b0, (l == 0 && r == 0), 1'b1);
                    for (int c = 0; c < cols; c++) add(K_MAC, l, r, c, s, corr, 1'b0, 1'b0, 1'b1);
                    add(K_BIAS, l, r, cols - 1, s, corr, 1'b0, 1'b0, 1'b1);
                    add(K_ACTS, l, r, cols - 1, s, corr, 1'b0, 1'b0, 1'b1);
                    for (int k = 0; k < n; k++) add(K_WAIT, l, r, cols - 1, s, corr, (k == n - 1), 1'b0, 1'b1);
                end
            end
            add(K_SCORE, 1, R1 - 1, C1 - 1, s, corr, 1'b0, 1'b0, 1'b1);
            if (match_a[s]) corr++;
        end
        add(K_DONE, 1, R1 - 1, C1 - 1, MI - 1, corr, 1'b0, 1'b0, 1'b1);
        add(K_DONE, 1, R1 - 1, C1 - 1, MI - 1, corr, 1'b0, 1'b0, 1'b1);
        add(K_DONE, 1, R1 - 1, C1 - 1, MI - 1, corr, 1'b0, 1'b0, 1'b0);
        add(K_IDLE, 1, R1 - 1, C1 - 1, MI - 1, corr, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check(string name, bit ok, string act, string req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%s required=%s", name, act, req);
        end
    endtask

    task automatic check_int(string name, int act, int req);
        check(name, act == req, $sformatf("%0d", act), $sformatf("%0d", req));
    endtask

    task automatic check_rec(string name, int i, rec_t e);
        bit [6:0] a_ctl, e_ctl;
        bit ok;
        a_ctl = {mac_clr, mac_en, bias_en, act_start, sample_done, final_done, busy};
        e_ctl = {e.clr, e.mac, e.bias, e.acts, e.sdone, e.fdone, e.busy};
        ok = (a_ctl === e_ctl) && (int'(layer_idx) == e.layer) && (int'(row_addr) == e.row)
             && (int'(col_addr) == e.col) && (int'(sample_idx) == e.sample)
             && (int'(correct_cnt) == e.correct);
        check($sformatf("%s[%0d]", name, i), ok,
              $sformatf("L%0d R%0d C%0d S%0d K%0d ctl=%b", layer_idx, row_addr, col_addr,
                        sample_idx, correct_cnt, a_ctl),
              $sformatf("L%0d R%0d C%0d S%0d K%0d ctl=%b", e.layer, e.row, e.col,
                        e.sample, e.correct, e_ctl));
    endtask

    task automatic check_all_zero(string name);
        check_int(name, int'({layer_idx, row_addr, col_addr, sample_idx, correct_cnt,
                              mac_clr, mac_en, bias_en, act_start, sample_done, final_done, busy}), 0);
    endtask

    // Starts from IDLE with enable low; abort_at/reset_at inject an event at that trace index.
    task automatic run_trace(string name, int abort_at, int reset_at);
        mac_cnt = 0; fd_first = -1; sd_cyc.delete();
        @(negedge clk);
        enable_inference = 1'b1; upload_done = 1'b1; act_done = 1'b0;
        for (int i = 0; i < trace.size(); i++) begin
            @(negedge clk);
            check_rec(name, i, trace[i]);
            if (mac_en) mac_cnt++;
            if (sample_done) sd_cyc.push_back(i + 1);
            if (final_done && fd_first < 0) fd_first = i + 1;
            if (i == abort_at) begin
                enable_inference = 1'b0;
                @(negedge clk);
                check_int({name, "_abort_busy"}, int'({busy, mac_en}), 0);
                check_int({name, "_abort_frozen_cnt"}, int'(correct_cnt), trace[i].correct);
                check_int({name, "_abort_frozen_sample"}, int'(sample_idx), trace[i].sample);
                return;
            end
            if (i == reset_at) begin
                rst_overall_n = 1'b0; act_done = 1'b1;
                @(negedge clk);
                check_all_zero({name, "_reset_mid_run"});
                rst_overall_n = 1'b1; act_done = 1'b0; enable_inference = 1'b0;
                return;
            end
            enable_inference = trace[i].en;
            act_done = trace[i].is_wait ? trace[i].act_req : 1'($urandom_range(0, 1));
            if (trace[i].new_samp) begin
                expected_output = $urandom_range(0, 1) ? 2'b01 : 2'b10;
                obtained_output = match_a[trace[i].sample] ? expected_output : ~expected_output;
            end
        end
    endtask

    initial begin
        rst_overall_n = 1'b0; enable_inference = 1'b1; upload_done = 1'b1;
        act_done = 1'b0; expected_output = '0; obtained_output = '0;

        for (int i = 0; i < 3; i++) tv[i] = '{0, 1, 1, 0, 0, 0, 0, 1};
        for (int i = 3; i < 13; i++) tv[i] = '{1, 1, 0, 0, 0, 0, 0, 1};
        tv[13] = '{1, 1, 1, 1, 1, 0, 0, 1};
        tv[14] = '{1, 1, 1, 1, 0, 1, 0, 1};
        tv[15] = '{1, 1, 1, 1, 0, 1, 0, 0};
        tv[16] = '{1, 0, 1, 0, 0, 0, 0, 0};
        tv[17] = '{1, 0, 1, 0, 0, 0, 0, 0};
        tv[18] = '{0, 0, 0, 0, 0, 0, 0, 1};

        @(negedge clk);
        for (int i = 0; i < 19; i++) begin
            rst_overall_n = tv[i].rst_n; enable_inference = tv[i].en; upload_done = tv[i].upl;
            @(negedge clk);
            check_int($sformatf("tv[%0d]_ctl", i), int'({busy, mac_clr, mac_en, final_done}),
                      int'({tv[i].busy, tv[i].clr, tv[i].mac, tv[i].fdone}));
            if (tv[i].zero)
                check_int($sformatf("tv[%0d]_zero", i),
                          int'({layer_idx, row_addr, col_addr, sample_idx, correct_cnt,
                                bias_en, act_start, sample_done}), 0);
        end
        rst_overall_n = 1'b1; enable_inference = 1'b0;
        repeat (2) @(negedge clk);

        // Full run, fast LUT, only sample 0 matches.
        match_a = '{1'b1, 1'b0};
        build(0);
        run_trace("full", -1, -1);
        check_int("full_mac_count", mac_cnt, MACS_PER_RUN);
        check_int("full_sample_done_0", (sd_cyc.size() > 0) ? sd_cyc[0] : -1, 39);
        check_int("full_sample_done_1", (sd_cyc.size() > 1) ? sd_cyc[1] : -1, 78);
        check_int("full_final_done_cycle", fd_first, 79);
        check_int("full_correct_cnt", int'(correct_cnt), 1);

        // Slow LUT on layer 0 row 1.
        build(1);
        run_trace("slow_lut", -1, -1);
        check_int("slow_mac_count", mac_cnt, MACS_PER_RUN);

        // Abort in layer-1 MAC of sample 1, then restart from zero.
        match_a = '{1'b1, 1'b0};
        build(0);
        run_trace("abort", 39 + R0 * 8 + 1, -1);
        repeat (2) @(negedge clk);
        check_int("abort_idle_busy", int'(busy), 0);
        build(0);
        run_trace("restart", -1, -1);

        // Reset during the first ACT_WAIT with act_done high.
        build(0);
        run_trace("reset_mid", -1, 1 + C0 + 2);
        repeat (2) @(negedge clk);

        for (int n = 0; n < 4; n++) begin
            for (int s = 0; s < MI; s++) match_a[s] = 1'($urandom_range(0, 1));
            build(2);
            run_trace($sformatf("rand%0d", n), -1, -1);
            check_int($sformatf("rand%0d_mac_count", n), mac_cnt, MACS_PER_RUN);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
